parity_frame_rx: RTL and testbench

- Serial frame receiver, the checking end of a parity-protected link.
- A transmitter elsewhere computes the reduction-XOR parity and sends one start bit, WIDTH data bits (LSB first), one parity bit and one stop bit.
- This block deserialises the frame and recomputes reduction XOR, AND and OR incrementally as bits arrive.
- It reports data, a parity error, a framing error, and all-ones / all-zero flags to downstream logic.

---
 rtl/parity_frame_rx_if.sv | 39 +++
 rtl/parity_frame_rx.sv | 128 ++++++++++++
 tb/tb_parity_frame_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_rx_if
//  Purpose  : Bundles the serial input strobe/bit and the decoded frame
//             results of the parity frame receiver.
//  Signals  : rx_en, rx_bit            - bit strobe and serial line (to rx)
//             data_out[WIDTH-1:0]      - last received data word
//             valid                    - one-cycle frame-complete pulse
//             parity_err, frame_err    - error status of the last frame
//             all_ones, all_zero       - reduction flags of the last word
//             busy                     - receiver is inside a frame
//  Modports : master - line driver / result consumer
//             slave  - the receiver
//  Revision : 1.0 - initial release
// ============================================================================
interface parity_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             rx_en;
    logic             rx_bit;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             all_ones;
    logic             all_zero;
    logic             busy;

    modport master (
        output rx_en, rx_bit,
        input  data_out, valid, parity_err, frame_err, all_ones, all_zero, busy
    );

    modport slave (
        input  rx_en, rx_bit,
        output data_out, valid, parity_err, frame_err, all_ones, all_zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_rx
//  Purpose  : Receiving end of a parity-protected serial link. Deserialises
//             start / WIDTH data bits (LSB first) / parity / stop, folding
//             reduction XOR, AND and OR into 1-bit accumulators as bits
//             arrive, and publishes the frame result in one registered update.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - parity_frame_rx_if.slave (strobe/bit in, results out)
//  Revision : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int WIDTH      = 8,
    parameter int ODD_PARITY = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    parity_frame_rx_if.slave  bus
);

    // Counter holds 0..WIDTH so it never wraps inside a frame.
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic               c_ODD   = (ODD_PARITY != 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_acc_xor;
    logic               r_acc_and;
    logic               r_acc_or;
    logic               r_pbit_err;

    logic [WIDTH-1:0]   r_data_out;
    logic               r_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_all_ones;
    logic               r_all_zero;

    logic [WIDTH-1:0]   w_shift_next;

    // Right shift with the new bit entering at the MSB: after WIDTH strobes
    // the first bit received sits in bit 0. A 1-bit word has nothing to keep.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shift_next = bus.rx_bit;
        end else begin : g_shift_wn
            assign w_shift_next = {bus.rx_bit, r_shift[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_acc_xor    <= 1'b0;
            r_acc_and    <= 1'b0;
            r_acc_or     <= 1'b0;
            r_pbit_err   <= 1'b0;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_all_ones   <= 1'b0;
            r_all_zero   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bus.rx_en) begin
                case (r_state)
                    c_IDLE: begin
                        if (!bus.rx_bit) begin
                            r_state   <= c_DATA;
                            r_cnt     <= '0;
                            r_acc_xor <= 1'b0;
                            r_acc_and <= 1'b1;
                            r_acc_or  <= 1'b0;
                        end
                    end
                    c_DATA: begin
                        r_shift   <= w_shift_next;
                        r_acc_xor <= r_acc_xor ^ bus.rx_bit;
                        r_acc_and <= r_acc_and & bus.rx_bit;
                        r_acc_or  <= r_acc_or | bus.rx_bit;
                        r_cnt     <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_state <= c_PARITY;
                        end
                    end
                    c_PARITY: begin
                        r_pbit_err <= r_acc_xor ^ bus.rx_bit ^ c_ODD;
                        r_state    <= c_STOP;
                    end
                    c_STOP: begin
                        // A bad stop bit still publishes the frame, flagged.
                        r_data_out   <= r_shift;
                        r_parity_err <= r_pbit_err;
                        r_frame_err  <= ~bus.rx_bit;
                        r_all_ones   <= r_acc_and;
                        r_all_zero   <= ~r_acc_or;
                        r_valid      <= 1'b1;
                        r_state      <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.all_ones   = r_all_ones;
    assign bus.all_zero   = r_all_zero;
    assign bus.busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_frame_rx
//  Purpose  : Self-checking bench for parity_frame_rx. Two receivers (even
//             and odd parity) share one serial line; each frame's expected
//             result is queued when issued and a monitor pops and compares
//             whenever the receivers pulse valid.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    localparam int c_WIDTH = 8;

    typedef struct {
        logic [7:0] data;
        logic       pe_even;
        logic       pe_odd;
        logic       fe;
        logic       ones;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rx_en;
    logic rx_bit;

    int   n_tests;
    int   n_fail;
    int   n_frame;
    exp_t q_exp[$];

    parity_frame_rx_if #(.WIDTH(c_WIDTH)) if_even ();
    parity_frame_rx_if #(.WIDTH(c_WIDTH)) if_odd ();

    assign if_even.rx_en  = rx_en;
    assign if_even.rx_bit = rx_bit;
    assign if_odd.rx_en   = rx_en;
    assign if_odd.rx_bit  = rx_bit;

    parity_frame_rx #(.WIDTH(c_WIDTH), .ODD_PARITY(0)) u_dut_even (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_even)
    );

    parity_frame_rx #(.WIDTH(c_WIDTH), .ODD_PARITY(1)) u_dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_odd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data_even"}, 32'(if_even.data_out),   32'h0);
        check({tag, "_valid_even"}, 32'(if_even.valid),     32'h0);
        check({tag, "_pe_even"},   32'(if_even.parity_err), 32'h0);
        check({tag, "_fe_even"},   32'(if_even.frame_err),  32'h0);
        check({tag, "_ones_even"}, 32'(if_even.all_ones),   32'h0);
        check({tag, "_zero_even"}, 32'(if_even.all_zero),   32'h0);
        check({tag, "_busy_even"}, 32'(if_even.busy),       32'h0);
        check({tag, "_data_odd"},  32'(if_odd.data_out),    32'h0);
        check({tag, "_valid_odd"}, 32'(if_odd.valid),       32'h0);
        check({tag, "_pe_odd"},    32'(if_odd.parity_err),  32'h0);
        check({tag, "_fe_odd"},    32'(if_odd.frame_err),   32'h0);
        check({tag, "_ones_odd"},  32'(if_odd.all_ones),    32'h0);
        check({tag, "_zero_odd"},  32'(if_odd.all_zero),    32'h0);
        check({tag, "_busy_odd"},  32'(if_odd.busy),        32'h0);
    endtask

    // One strobed bit, optionally preceded by gap cycles of line noise.
    task automatic strobe(input logic b, input int gap_n);
        repeat (gap_n) begin
            rx_en  = 1'b0;
            rx_bit = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rx_en  = 1'b1;
        rx_bit = b;
        @(posedge clk);
        #1;
        rx_en  = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rx_en  = 1'b1;
            rx_bit = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap_n,
                              input logic pe_e, input logic pe_o, input logic fe,
                              input logic ones, input logic zero, input bit chk_busy);
        exp_t e;
        e.data    = d;
        e.pe_even = pe_e;
        e.pe_odd  = pe_o;
        e.fe      = fe;
        e.ones    = ones;
        e.zero    = zero;
        q_exp.push_back(e);
        strobe(1'b0, gap_n);
        if (chk_busy) begin
            check("busy_after_start_even", 32'(if_even.busy), 32'h1);
            check("busy_after_start_odd",  32'(if_odd.busy),  32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            strobe(d[i], gap_n);
        end
        strobe(p, gap_n);
        if (chk_busy) begin
            check("busy_before_stop_even", 32'(if_even.busy), 32'h1);
        end
        strobe(s, gap_n);
        if (chk_busy) begin
            check("busy_after_stop_even", 32'(if_even.busy), 32'h0);
            check("busy_after_stop_odd",  32'(if_odd.busy),  32'h0);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the
    // active edge, and pops one expectation per valid pulse.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (if_even.valid || if_odd.valid)) begin
                check($sformatf("f%0d_valid_width", n_frame), 32'(prev_valid), 32'h0);
                check($sformatf("f%0d_valid_even", n_frame), 32'(if_even.valid), 32'h1);
                check($sformatf("f%0d_valid_odd", n_frame),  32'(if_odd.valid),  32'h1);
                check($sformatf("f%0d_expected_pending", n_frame), 32'(q_exp.size() != 0), 32'h1);
                if (q_exp.size() != 0) begin
                    e = q_exp.pop_front();
                    check($sformatf("f%0d_data_even", n_frame), 32'(if_even.data_out),   32'(e.data));
                    check($sformatf("f%0d_data_odd", n_frame),  32'(if_odd.data_out),    32'(e.data));
                    check($sformatf("f%0d_pe_even", n_frame),   32'(if_even.parity_err), 32'(e.pe_even));
                    check($sformatf("f%0d_pe_odd", n_frame),    32'(if_odd.parity_err),  32'(e.pe_odd));
                    check($sformatf("f%0d_fe_even", n_frame),   32'(if_even.frame_err),  32'(e.fe));
                    check($sformatf("f%0d_fe_odd", n_frame),    32'(if_odd.frame_err),   32'(e.fe));
                    check($sformatf("f%0d_ones_even", n_frame), 32'(if_even.all_ones),   32'(e.ones));
                    check($sformatf("f%0d_ones_odd", n_frame),  32'(if_odd.all_ones),    32'(e.ones));
                    check($sformatf("f%0d_zero_even", n_frame), 32'(if_even.all_zero),   32'(e.zero));
                    check($sformatf("f%0d_zero_odd", n_frame),  32'(if_odd.all_zero),    32'(e.zero));
                end
                n_frame++;
            end
            prev_valid = rst_n && if_even.valid;
        end
    end

    // Output invariants on every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && if_even.valid) begin
                assert (if_even.all_ones == (&if_even.data_out))
                    else $error("invariant all_ones vs data_out broken");
                assert (if_even.all_zero == ~(|if_even.data_out))
                    else $error("invariant all_zero vs data_out broken");
                assert (!(if_even.all_ones && if_even.all_zero))
                    else $error("invariant all_ones and all_zero both set");
            end
            if (rst_n && if_odd.valid) begin
                assert (if_odd.all_ones == (&if_odd.data_out))
                    else $error("invariant all_ones vs data_out broken (odd)");
                assert (if_odd.all_zero == ~(|if_odd.data_out))
                    else $error("invariant all_zero vs data_out broken (odd)");
                assert (!(if_odd.all_ones && if_odd.all_zero))
                    else $error("invariant all_ones and all_zero both set (odd)");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_frame = 0;
        rx_en   = 1'b0;
        rx_bit  = 1'b1;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        idle(2);

        //         data   p     s     gap  pe_e  pe_o  fe    ones  zero  busy
        send_frame(8'hA5, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        send_frame(8'hFF, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_frame(8'hFF, 1'b1, 1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_frame(8'h00, 1'b0, 1'b0, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        // Strobe every third cycle, noise on the line in between.
        send_frame(8'h3C, 1'b0, 1'b1, 2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Abandon a frame after four data bits of 0x81 (LSB first: 1,0,0,0).
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset("midframe_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send_frame(8'h81, 1'b0, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Back-to-back frames, start bit right after the stop bit.
        send_frame(8'h01, 1'b1, 1'b1, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7F, 1'b0, 1'b1, 0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        check("all_frames_seen", 32'(q_exp.size()), 32'h0);
        check("frame_count", 32'(n_frame), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
